// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port arbiter and sequencer for the single-port negedge mips RAM
// RAM controls launch from posedge flops so they are settled at the RAM's negedge inside ISSUE.
module mem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_adr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_adr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          ram_memwrite,
  output logic [AW-1:0] ram_adr,
  output logic [DW-1:0] ram_writedata,
  input  logic [DW-1:0] ram_memdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;

  state_t        state, state_nxt;
  logic          cur, cur_nxt;
  logic          last_gnt, last_gnt_nxt;
  logic          winner;
  logic          memwrite_nxt;
  logic [AW-1:0] adr_nxt;
  logic [DW-1:0] wdata_nxt;
  logic          p0_ack_nxt, p1_ack_nxt;
  logic [DW-1:0] p0_rdata_nxt, p1_rdata_nxt;

  // On a tie, fixed mode favours port 0; round-robin favours the port not served last.
  always_comb begin
    winner = p1_req;
    if (p0_req && p1_req) begin
      winner = (FIXED_PRI != 0) ? 1'b0 : ~last_gnt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cur_nxt      = cur;
    last_gnt_nxt = last_gnt;
    memwrite_nxt = ram_memwrite;
    adr_nxt      = ram_adr;
    wdata_nxt    = ram_writedata;
    p0_ack_nxt   = 1'b0;
    p1_ack_nxt   = 1'b0;
    p0_rdata_nxt = p0_rdata;
    p1_rdata_nxt = p1_rdata;
    case (state)
      IDLE: begin
        memwrite_nxt = 1'b0;
        if (p0_req || p1_req) begin
          adr_nxt      = winner ? p1_adr   : p0_adr;
          wdata_nxt    = winner ? p1_wdata : p0_wdata;
          memwrite_nxt = winner ? p1_we    : p0_we;
          cur_nxt      = winner;
          last_gnt_nxt = winner;
          state_nxt    = ISSUE;
        end
      end
      ISSUE: begin
        // After a write the RAM echoes the written byte, so rdata equals wdata.
        if (cur) begin
          p1_rdata_nxt = ram_memdata;
          p1_ack_nxt   = 1'b1;
        end else begin
          p0_rdata_nxt = ram_memdata;
          p0_ack_nxt   = 1'b1;
        end
        memwrite_nxt = 1'b0;
        state_nxt    = ACK;
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        memwrite_nxt = 1'b0;
        state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cur           <= 1'b0;
      last_gnt      <= 1'b1;
      ram_memwrite  <= 1'b0;
      ram_adr       <= '0;
      ram_writedata <= '0;
      p0_ack        <= 1'b0;
      p1_ack        <= 1'b0;
      p0_rdata      <= '0;
      p1_rdata      <= '0;
    end else begin
      state         <= state_nxt;
      cur           <= cur_nxt;
      last_gnt      <= last_gnt_nxt;
      ram_memwrite  <= memwrite_nxt;
      ram_adr       <= adr_nxt;
      ram_writedata <= wdata_nxt;
      p0_ack        <= p0_ack_nxt;
      p1_ack        <= p1_ack_nxt;
      p0_rdata      <= p0_rdata_nxt;
      p1_rdata      <= p1_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter, round-robin (inst 0) and fixed-priority (inst 1)
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       req   [2][2];
  logic       we    [2][2];
  logic [7:0] adr   [2][2];
  logic [7:0] wdata [2][2];
  logic       ack   [2][2];
  logic [7:0] rdata [2][2];
  logic       ram_we [2];
  logic [7:0] ram_adr [2];
  logic [7:0] ram_wd [2];
  logic [7:0] ram_md [2];
  logic [7:0] mem [2][256];

  generate
    for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_arbiter #(.AW(8), .DW(8), .FIXED_PRI(g)) u_dut (
        .clk(clk), .reset(reset),
        .p0_req(req[g][0]), .p0_we(we[g][0]), .p0_adr(adr[g][0]), .p0_wdata(wdata[g][0]),
        .p0_ack(ack[g][0]), .p0_rdata(rdata[g][0]),
        .p1_req(req[g][1]), .p1_we(we[g][1]), .p1_adr(adr[g][1]), .p1_wdata(wdata[g][1]),
        .p1_ack(ack[g][1]), .p1_rdata(rdata[g][1]),
        .ram_memwrite(ram_we[g]), .ram_adr(ram_adr[g]), .ram_writedata(ram_wd[g]),
        .ram_memdata(ram_md[g])
      );
    end
  endgenerate

  // RAM model: write and read on negedge, written byte echoed on memdata
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ram_we[i]) mem[i][ram_adr[i]] = ram_wd[i];
      ram_md[i] <= ram_we[i] ? ram_wd[i] : mem[i][ram_adr[i]];
    end
  end

  typedef struct { int port; logic [7:0] data; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mw_cnt [2];
  logic mw_prev [2];
  logic [7:0] last_rd [2][2];
  int last_ack_cyc = -1;
  bit rr_phase = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void push(input int i, input int p, input logic [7:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    if (i == 0) q0.push_back(e); else q1.push_back(e);
  endfunction

  // Monitor: sampled on negedge, away from the posedge where outputs change
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mw_prev[i] = 1'b0;
        last_rd[i][0] = 8'h00;
        last_rd[i][1] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        chk("acks_exclusive", ack[i][0] & ack[i][1], 0);
        if (mw_prev[i]) chk("ack_after_write", ack[i][0] | ack[i][1], 1);
        if (ram_we[i]) begin
          mw_cnt[i]++;
          chk("memwrite_single_cycle", mw_prev[i], 0);
        end
        mw_prev[i] = ram_we[i];
        for (int p = 0; p < 2; p++) begin
          if (ack[i][p]) begin
            chk("ack_expected", ((i == 0) ? q0.size() : q1.size()) > 0, 1);
            if (((i == 0) ? q0.size() : q1.size()) > 0) begin
              if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
              chk("ack_port", p, e.port);
              chk("rdata", rdata[i][p], e.data);
              chk("other_rdata_held", rdata[i][1-p], last_rd[i][1-p]);
              last_rd[i][p] = e.data;
            end
            if (rr_phase && i == 0) begin
              if (last_ack_cyc >= 0) chk("rr_ack_spacing", cyc - last_ack_cyc, 3);
              last_ack_cyc = cyc;
            end
          end
        end
      end
    end
  end

  // mode 0: drop req when ack seen; 1: hold one more edge; 2: keep req for a follow-on access
  task automatic access(input int i, input int p, input logic w, input logic [7:0] a,
                        input logic [7:0] d, input int lat, input int mode);
    int n = 0;
    we[i][p] = w; adr[i][p] = a; wdata[i][p] = d; req[i][p] = 1'b1;
    while (!ack[i][p] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_within_budget", n < 20, 1);
    if (lat >= 0) chk("ack_latency", n, lat);
    if (mode == 0) req[i][p] = 1'b0;
    @(posedge clk); #1;
    if (mode == 1) req[i][p] = 1'b0;
  endtask

  initial begin
    int m;
    for (int i = 0; i < 2; i++) begin
      mw_cnt[i] = 0;
      mw_prev[i] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        req[i][p] = 0; we[i][p] = 0; adr[i][p] = 0; wdata[i][p] = 0; last_rd[i][p] = 0;
      end
      for (int k = 0; k < 256; k++) mem[i][k] = 8'h00;
      mem[i][8'h00] = 8'h3C;
      mem[i][8'h01] = 8'hC3;
    end
    mem[0][8'h10] = 8'h77;
    mem[0][8'hFF] = 8'h03;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("reset_ram_outputs", {ram_we[i], ram_adr[i], ram_wd[i]}, 0);
      chk("reset_acks", {ack[i][0], ack[i][1]}, 0);
      chk("reset_rdata", {rdata[i][0], rdata[i][1]}, 0);
    end

    // Reset lands mid-ISSUE of a write: memwrite must fall at once, no ack, RAM untouched
    @(posedge clk); #1;
    we[0][0] = 1; adr[0][0] = 8'h10; wdata[0][0] = 8'h5A; req[0][0] = 1;
    @(posedge clk); #1;
    chk("issue_memwrite_high", ram_we[0], 1);
    chk("issue_adr", ram_adr[0], 8'h10);
    #1 reset = 1'b1;
    #1 chk("memwrite_async_drop", ram_we[0], 0);
    req[0][0] = 0;
    @(posedge clk); #1;
    chk("reset_mid_outputs", {ram_we[0], ram_adr[0], ram_wd[0], ack[0][0], ack[0][1]}, 0);
    chk("reset_mid_rdata", {rdata[0][0], rdata[0][1]}, 0);
    @(posedge clk); #1;
    chk("aborted_write_mem", mem[0][8'h10], 8'h77);
    reset = 1'b0;
    @(posedge clk); #1;

    // Port 0 write then read back
    m = mw_cnt[0];
    push(0, 0, 8'hA5);
    access(0, 0, 1'b1, 8'h20, 8'hA5, 2, 0);
    chk("write_memwrite_cycles", mw_cnt[0] - m, 1);
    chk("write_mem", mem[0][8'h20], 8'hA5);
    push(0, 0, 8'hA5);
    access(0, 0, 1'b0, 8'h20, 8'h00, 2, 0);
    chk("p1_rdata_untouched", rdata[0][1], 0);

    // Requester holds req through the ACK-closing edge: no second ISSUE
    push(0, 0, 8'h3C);
    access(0, 0, 1'b0, 8'h00, 8'h00, 2, 1);
    repeat (4) @(posedge clk);
    #1;

    // Port 1 read of the top address
    m = mw_cnt[0];
    push(0, 1, 8'h03);
    access(0, 1, 1'b0, 8'hFF, 8'h00, 2, 0);
    chk("read_no_memwrite", mw_cnt[0] - m, 0);

    // Round-robin: both held, acks alternate at 3-cycle spacing
    push(0, 0, 8'h3C); push(0, 1, 8'hC3); push(0, 0, 8'h3C); push(0, 1, 8'hC3);
    rr_phase = 1;
    fork
      begin
        access(0, 0, 1'b0, 8'h00, 8'h00, -1, 2);
        access(0, 0, 1'b0, 8'h00, 8'h00, -1, 0);
      end
      begin
        access(0, 1, 1'b0, 8'h01, 8'h00, -1, 2);
        access(0, 1, 1'b0, 8'h01, 8'h00, -1, 0);
      end
    join
    rr_phase = 0;

    // Fixed priority: port 1 waits until port 0 drops its request
    push(1, 0, 8'h3C); push(1, 0, 8'h3C); push(1, 0, 8'h3C); push(1, 1, 8'hC3);
    fork
      begin
        for (int k = 0; k < 3; k++) access(1, 0, 1'b0, 8'h00, 8'h00, -1, (k == 2) ? 0 : 2);
      end
      begin
        access(1, 1, 1'b0, 8'h01, 8'h00, -1, 0);
      end
    join

    repeat (5) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 256x8 mips RAM.
- The RAM performs its write and read on the negedge of clk.
- Port 0 is the mips processor memory interface; port 1 is a secondary master (loader/DMA/debug).
- The block serialises accesses, drives the RAM control/address/data from posedge flops so they are stable at the RAM's negedge, and returns captured read data with a one-cycle ack pulse.

Parameters:
- AW, 8, address width (RAM depth 2**AW).
- DW, 8, data width.
- FIXED_PRI, 0, 0 = round-robin between ports; 1 = port 0 always wins ties.

Ports:
- clk  input  1  system clock; all block state on posedge.
- reset  input  1  asynchronous, active-high reset.
- p0_req  input  1  port 0 access request; held high until p0_ack.
- p0_we  input  1  port 0 write enable (1 = write, 0 = read); stable while p0_req is high.
- p0_adr  input  AW  port 0 address; stable while p0_req is high.
- p0_wdata  input  DW  port 0 write data; stable while p0_req is high.
- p0_ack  output  1  one-cycle completion pulse to port 0.
- p0_rdata  output  DW  port 0 returned data; valid from p0_ack and held until the next p0_ack.
- p1_req, p1_we, p1_adr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1.
- ram_memwrite  output  1  to RAM memwrite.
- ram_adr  output  AW  to RAM adr.
- ram_writedata  output  DW  to RAM writedata.
- ram_memdata  input  DW  from RAM memdata.

Behaviour:
- FSM states: IDLE, ISSUE, ACK. All state and outputs are registered on the posedge of clk.
- Reset (asynchronous, active-high):
  - state = IDLE.
  - ram_memwrite = 0, ram_adr = 0, ram_writedata = 0.
  - p0_ack = p1_ack = 0, p0_rdata = p1_rdata = 0.
  - last_gnt = 1, so port 0 wins the first tie.
- IDLE:
  - No request: stay in IDLE, ram_memwrite = 0.
  - Exactly one request: grant it.
  - Both requests and FIXED_PRI = 1: grant port 0.
  - Both requests and FIXED_PRI = 0: grant the port != last_gnt.
  - On grant: register the winner's adr/wdata/we into ram_adr/ram_writedata/ram_memwrite, set cur = winner, set last_gnt = winner, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - RAM outputs are held stable; the RAM acts on the negedge inside this cycle.
  - At the closing posedge: capture ram_memdata into p<cur>_rdata, pulse p<cur>_ack = 1, force ram_memwrite = 0, go to ACK.
- ACK (exactly 1 cycle):
  - The ack is high during this cycle.
  - Requests are ignored, so a req still high at the closing edge is not re-issued.
  - At the closing posedge: ack returns to 0, go to IDLE.
- Requester rule: drop req (or present a new access) at the edge where it samples ack = 1.
- Latency and throughput:
  - req sampled in IDLE -> ack 2 cycles later.
  - Maximum throughput is 1 access per 3 cycles.
  - A losing requester waits at most 3 cycles in round-robin mode.
- Write completion: ram_memdata carries the newly written byte, so rdata after a write equals wdata.
- ram_adr and ram_writedata hold their last values outside ISSUE. ram_memwrite is 1 only during ISSUE of a write.
- The rdata of the non-granted port never changes.
- Reset asserted in ISSUE before the negedge: ram_memwrite drops immediately, the write is aborted, no ack is produced.
- Reset asserted in ACK: the ack is cut short and the FSM returns to IDLE.
- Address wrap: none inside the block; the address passes straight through.
- FIXED_PRI = 1 may starve port 1 by design.

Test Plan:
- Reset mid-ISSUE during a port 0 write of 0x5A to address 0x10 -> ram_memwrite falls asynchronously, no p0_ack, RAM[0x10] unchanged, all outputs 0.
- Port 0 write of 0xA5 to address 0x20, then port 0 read of 0x20:
  - ram_memwrite is high for exactly 1 cycle.
  - p0_ack follows 2 cycles after req.
  - The read returns p0_rdata = 0xA5.
  - p1_rdata stays 0.
- Port 1 read of address 0xFF with RAM preloaded to 0x03 -> p1_ack after 2 cycles, p1_rdata = 0x03, ram_memwrite stays 0.
- Both requests held continuously, FIXED_PRI = 0 (port 0 reads 0x00, port 1 reads 0x01) -> acks alternate p0, p1, p0, p1 at 3-cycle spacing, never two consecutive acks to the same port.
- Same stimulus with FIXED_PRI = 1 -> only p0_ack pulses; p1 is granted only after p0_req drops.
- Requester holds req 1 cycle past ack (protocol check) -> no duplicate ISSUE. Assertions: ram_memwrite is never high outside ISSUE; p0_ack and p1_ack are never high together.
